// File: rtl/ucaspian_pkg.sv
// rtl/ucaspian_pkg.sv - shared state type, count-width helper and default parameters for the uCaspian run controller
package ucaspian_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STEP  = 2'd1,
    CLEAR = 2'd2
  } run_state_t;

  localparam int DEF_NUM_UNITS     = 5;
  localparam int DEF_TIME_W        = 32;
  localparam int DEF_TGT_W         = 8;
  localparam int DEF_ADDR_W        = 8;
  localparam int DEF_OUT_DEPTH     = 4;
  localparam int DEF_SETTLE_CYCLES = 2;

  // Bits needed to hold any count in 0..max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ucaspian_fire_fifo.sv
// rtl/ucaspian_fire_fifo.sv - first-word fall-through fire FIFO (pointer + count), synchronous flush
module ucaspian_fire_fifo
  import ucaspian_pkg::*;
#(
  parameter int DEPTH = DEF_OUT_DEPTH,
  parameter int WIDTH = DEF_ADDR_W
) (
  input  logic             clk,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_vld,
  output logic             push_rdy,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_vld,
  input  logic             pop_rdy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  assign push_rdy = (count != FULL_CNT);
  assign pop_vld  = (count != '0);
  assign pop_data = mem[rd_ptr];
  assign push     = push_vld && push_rdy;
  assign pop      = pop_vld && pop_rdy;

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ucaspian_run_ctrl.sv
// rtl/ucaspian_run_ctrl.sv - uCaspian run/time-step controller; UCASPIAN_RUN_CTRL_METRICS_EN adds step/fire metrics
module ucaspian_run_ctrl
  import ucaspian_pkg::*;
#(
  parameter int NUM_UNITS     = DEF_NUM_UNITS,
  parameter int TIME_W        = DEF_TIME_W,
  parameter int TGT_W         = DEF_TGT_W,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int OUT_DEPTH     = DEF_OUT_DEPTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [NUM_UNITS-1:0] unit_clear_done,
  output logic                 clear_done,
  input  logic                 ack_sent,
  input  logic [TGT_W-1:0]     target_value,
  input  logic                 target_vld,
  output logic                 target_rdy,
  input  logic [NUM_UNITS-1:0] unit_step_done,
  output logic                 next_step,
  output logic [TIME_W-1:0]    time_current,
  output logic                 time_remaining,
  output logic                 time_update,
  input  logic                 time_sent,
  output logic                 active,
  input  logic [ADDR_W-1:0]    fire_in_addr,
  input  logic                 fire_in_vld,
  output logic                 fire_in_rdy,
  output logic [ADDR_W-1:0]    fire_out_addr,
  output logic                 fire_out_vld,
  input  logic                 fire_out_rdy
`ifdef UCASPIAN_RUN_CTRL_METRICS_EN
  ,
  output logic [31:0]          metric_step_cycles,
  output logic [31:0]          metric_fire_count
`endif
);

  localparam int SET_W = cnt_w(SETTLE_CYCLES);
  localparam logic [SET_W-1:0]  SETTLE_MAX = SET_W'(SETTLE_CYCLES);
  localparam logic [TIME_W-1:0] TIME_MAX   = '1;

  run_state_t        state;
  run_state_t        state_nxt;
  logic              go_step;
  logic [SET_W-1:0]  settle_cnt;
  logic [TIME_W-1:0] target_time;
  logic [TIME_W:0]   target_sum;
  logic              flush;
  logic              all_done;
  logic              fifo_push_rdy;
  logic              fifo_empty;

  assign flush          = reset || clear;
  assign all_done       = &unit_step_done;
  assign target_rdy     = !reset && !clear;
  assign time_remaining = (target_time > time_current);
  assign active         = !reset && !clear && time_remaining;
  assign next_step      = (state == STEP);
  assign fifo_empty     = !fire_out_vld;
  assign fire_in_rdy    = fifo_push_rdy && !reset;
  assign target_sum     = {1'b0, target_time} + (TIME_W+1)'(target_value);

  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    go_step   = 1'b0;
    case (state)
      RUN: begin
        if (all_done && (settle_cnt == SETTLE_MAX) && fifo_empty && time_remaining) begin
          state_nxt = STEP;
          go_step   = 1'b1;
        end
      end
      STEP:    state_nxt = RUN;
      CLEAR:   state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
    if (clear) begin
      state_nxt = CLEAR;
      go_step   = 1'b0;
    end
  end

  // Settle window only counts uninterrupted all-done cycles spent in RUN.
  always_ff @(posedge clk) begin
    if (flush || (state != RUN) || !all_done) settle_cnt <= '0;
    else if (settle_cnt != SETTLE_MAX)        settle_cnt <= settle_cnt + SET_W'(1);
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      time_current <= '0;
      target_time  <= '0;
    end else begin
      if (go_step) time_current <= time_current + TIME_W'(1);
      if (target_vld && target_rdy)
        target_time <= target_sum[TIME_W] ? TIME_MAX : target_sum[TIME_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)          time_update <= 1'b0;
    else if (go_step)   time_update <= 1'b1;
    else if (time_sent) time_update <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset || ack_sent)                clear_done <= 1'b0;
    else if (clear && (&unit_clear_done)) clear_done <= 1'b1;
  end

  ucaspian_fire_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (ADDR_W)
  ) u_fire_fifo (
    .clk       (clk),
    .flush     (flush),
    .push_data (fire_in_addr),
    .push_vld  (fire_in_vld && !reset),
    .push_rdy  (fifo_push_rdy),
    .pop_data  (fire_out_addr),
    .pop_vld   (fire_out_vld),
    .pop_rdy   (fire_out_rdy)
  );

`ifdef UCASPIAN_RUN_CTRL_METRICS_EN
  logic [31:0] run_cycles;
  logic        fire_push;

  assign fire_push = fire_in_vld && fire_in_rdy;

  // A step's length counts the RUN cycles leading up to it, including the launching cycle.
  always_ff @(posedge clk) begin
    if (flush) begin
      run_cycles         <= '0;
      metric_step_cycles <= '0;
      metric_fire_count  <= '0;
    end else begin
      if (state == RUN) begin
        if (go_step) begin
          metric_step_cycles <= sat_inc32(run_cycles);
          run_cycles         <= '0;
        end else begin
          run_cycles <= sat_inc32(run_cycles);
        end
      end else begin
        run_cycles <= '0;
      end
      if (fire_push) metric_fire_count <= sat_inc32(metric_fire_count);
    end
  end
`endif

endmodule
